// File: rtl/branch_resolve_if.sv
// Branch resolution bus: EX-stage control-flow operands in, fetch redirect,
// wrong-path flush and predictor training out.
interface branch_resolve_if;
    logic        ex_valid;
    logic [1:0]  ex_kind;
    logic        cmp_f;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall;

    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        bht_upd_o;
    logic [31:0] bht_upd_pc_o;
    logic        bht_upd_taken_o;

    modport master (
        output ex_valid, ex_kind, cmp_f, ex_pc, ex_imm, ex_rs1,
               pred_taken, pred_target, stall,
        input  redirect_o, redirect_pc_o, flush_o,
               bht_upd_o, bht_upd_pc_o, bht_upd_taken_o
    );

    modport slave (
        input  ex_valid, ex_kind, cmp_f, ex_pc, ex_imm, ex_rs1,
               pred_taken, pred_target, stall,
        output redirect_o, redirect_pc_o, flush_o,
               bht_upd_o, bht_upd_pc_o, bht_upd_taken_o
    );
endinterface

// File: rtl/branch_resolve.sv
// Resolves EX-stage branches/jumps against the fetch prediction, redirects
// fetch and squashes IF/ID on a mispredict. Define BR_STATS_EN for counters.
//
// state  | meaning
// IDLE   | resolving control-flow instructions from EX
// SQUASH | flushing two wrong-path slots; EX inputs are ignored
module branch_resolve (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  br
`ifdef BR_STATS_EN
    ,
    output logic [31:0]      stat_branches_o,
    output logic [31:0]      stat_mispred_o
`endif
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SQUASH = 1'b1;

    localparam logic [1:0] KIND_BR   = 2'b01;
    localparam logic [1:0] KIND_JALR = 2'b11;

    logic [0:0]  state_q;
    logic [1:0]  squash_cnt_q;

    logic [31:0] target_sum;
    logic [31:0] target;
    logic        taken;
    logic [31:0] next_pc;
    logic        resolve;
    logic        mispred;
    logic        bht_event;

    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic        bht_upd_q;
    logic [31:0] bht_upd_pc_q;
    logic        bht_upd_taken_q;

    assign target_sum = (br.ex_kind == KIND_JALR) ? (br.ex_rs1 + br.ex_imm)
                                                  : (br.ex_pc + br.ex_imm);
    assign target     = (br.ex_kind == KIND_JALR) ? {target_sum[31:1], 1'b0}
                                                  : target_sum;
    assign taken      = (br.ex_kind == KIND_BR) ? br.cmp_f : 1'b1;
    assign next_pc    = taken ? target : (br.ex_pc + 32'd4);

    assign resolve    = br.ex_valid && (br.ex_kind != 2'b00) && !br.stall
                        && (state_q == IDLE);
    assign mispred    = resolve && ((br.pred_taken != taken)
                        || (taken && (br.pred_target != target)));
    assign bht_event  = resolve && (br.ex_kind == KIND_BR);

    // The squash counter only advances on unstalled cycles, so a frozen
    // pipeline keeps the wrong-path slots flushed until they drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            squash_cnt_q <= 2'd0;
        end else if (state_q == IDLE) begin
            if (mispred) begin
                state_q      <= SQUASH;
                squash_cnt_q <= 2'd2;
            end
        end else if (!br.stall) begin
            squash_cnt_q <= squash_cnt_q - 2'd1;
            if (squash_cnt_q <= 2'd1) begin
                state_q <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q      <= 1'b0;
            redirect_pc_q   <= 32'd0;
            bht_upd_q       <= 1'b0;
            bht_upd_pc_q    <= 32'd0;
            bht_upd_taken_q <= 1'b0;
        end else begin
            redirect_q <= mispred;
            bht_upd_q  <= bht_event;
            if (mispred) begin
                redirect_pc_q <= next_pc;
            end
            if (bht_event) begin
                bht_upd_pc_q    <= br.ex_pc;
                bht_upd_taken_q <= taken;
            end
        end
    end

    assign br.redirect_o      = redirect_q;
    assign br.redirect_pc_o   = redirect_pc_q;
    assign br.flush_o         = (state_q == SQUASH);
    assign br.bht_upd_o       = bht_upd_q;
    assign br.bht_upd_pc_o    = bht_upd_pc_q;
    assign br.bht_upd_taken_o = bht_upd_taken_q;

`ifdef BR_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispred_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else begin
            if (resolve && (stat_branches_q != 32'hFFFF_FFFF)) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (mispred && (stat_mispred_q != 32'hFFFF_FFFF)) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign stat_branches_o = stat_branches_q;
    assign stat_mispred_o  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_branch_resolve;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    branch_resolve_if bif ();

`ifdef BR_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
    branch_resolve dut (.clk(clk), .rst_n(rst_n), .br(bif),
                        .stat_branches_o(stat_branches), .stat_mispred_o(stat_mispred));
`else
    branch_resolve dut (.clk(clk), .rst_n(rst_n), .br(bif));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of a control-flow instruction.
    function automatic void ref_resolve(input logic [1:0] kind, input logic cmp,
                                        input logic [31:0] pc, input logic [31:0] imm,
                                        input logic [31:0] rs1, output logic [31:0] tgt,
                                        output logic tk, output logic [31:0] nxt);
        if (kind == 2'b11) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
        else               tgt = pc + imm;
        tk  = (kind == 2'b01) ? cmp : 1'b1;
        nxt = tk ? tgt : pc + 32'd4;
    endfunction

    // Behavioural model: expected outputs for the cycle after each edge.
    logic        m_redir, m_bht, m_btaken;
    logic [31:0] m_rpc, m_bpc, m_br, m_mp;
    int          m_flush_left;
    logic [31:0] mt, mn;
    logic        mk, m_ev, m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_redir = 0; m_rpc = 0; m_bht = 0; m_bpc = 0; m_btaken = 0;
            m_flush_left = 0; m_br = 0; m_mp = 0;
        end else begin
            m_ev = bif.ex_valid && bif.ex_kind != 2'b00 && !bif.stall && m_flush_left == 0;
            ref_resolve(bif.ex_kind, bif.cmp_f, bif.ex_pc, bif.ex_imm, bif.ex_rs1, mt, mk, mn);
            m_mis = m_ev && (bif.pred_taken != mk || (mk && bif.pred_target != mt));
            if (m_flush_left > 0 && !bif.stall) m_flush_left--;
            m_redir = m_mis;
            m_bht   = m_ev && bif.ex_kind == 2'b01;
            if (m_mis) begin
                m_rpc = mn;
                m_flush_left = 2;
            end
            if (m_bht) begin
                m_bpc = bif.ex_pc;
                m_btaken = mk;
            end
            if (m_ev && m_br != 32'hFFFF_FFFF) m_br++;
            if (m_mis && m_mp != 32'hFFFF_FFFF) m_mp++;
        end
    end

    always @(negedge clk) begin
        chk("redirect_o", bif.redirect_o, m_redir);
        chk("redirect_pc_o", bif.redirect_pc_o, m_rpc);
        chk("flush_o", bif.flush_o, m_flush_left > 0);
        chk("bht_upd_o", bif.bht_upd_o, m_bht);
        chk("bht_upd_pc_o", bif.bht_upd_pc_o, m_bpc);
        if (m_bht) chk("bht_upd_taken_o", bif.bht_upd_taken_o, m_btaken);
`ifdef BR_STATS_EN
        chk("stat_branches_o", stat_branches, m_br);
        chk("stat_mispred_o", stat_mispred, m_mp);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.ex_valid = 0; bif.ex_kind = 2'b00; bif.cmp_f = 0;
        bif.ex_pc = 0; bif.ex_imm = 0; bif.ex_rs1 = 0;
        bif.pred_taken = 0; bif.pred_target = 0; bif.stall = 0;
    endtask

    task automatic drive(input logic [1:0] kind, input logic cmp, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1,
                         input logic pt, input logic [31:0] ptgt);
        bif.ex_valid = 1; bif.ex_kind = kind; bif.cmp_f = cmp;
        bif.ex_pc = pc; bif.ex_imm = imm; bif.ex_rs1 = rs1;
        bif.pred_taken = pt; bif.pred_target = ptgt; bif.stall = 0;
    endtask

    initial begin
        logic [31:0] tgt, nxt;
        logic        tk;
        n_vec = 0;
        n_err = 0;
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset redirect_o", bif.redirect_o, 0);
        chk("reset flush_o", bif.flush_o, 0);
        chk("reset bht_upd_o", bif.bht_upd_o, 0);
        chk("reset redirect_pc_o", bif.redirect_pc_o, 0);
        chk("reset bht_upd_pc_o", bif.bht_upd_pc_o, 0);
        rst_n = 1;
        tick();

        // Taken BEQ predicted not-taken.
        drive(2'b01, 1, 32'h100, 32'h20, 0, 0, 0);
        tick(); idle();
        chk("beq redirect_o", bif.redirect_o, 1);
        chk("beq redirect_pc_o", bif.redirect_pc_o, 32'h120);
        chk("beq flush N+1", bif.flush_o, 1);
        chk("beq bht_upd_o", bif.bht_upd_o, 1);
        chk("beq bht_upd_taken_o", bif.bht_upd_taken_o, 1);
        chk("beq bht_upd_pc_o", bif.bht_upd_pc_o, 32'h100);
        tick();
        chk("beq flush N+2", bif.flush_o, 1);
        chk("beq redirect N+2", bif.redirect_o, 0);
        tick();
        chk("beq flush N+3", bif.flush_o, 0);

        // Correctly predicted JALR with odd sum.
        drive(2'b11, 0, 32'h500, 32'h4, 32'h2003, 1, 32'h2006);
        tick(); idle();
        chk("jalr redirect_o", bif.redirect_o, 0);
        chk("jalr flush_o", bif.flush_o, 0);
        chk("jalr bht_upd_o", bif.bht_upd_o, 0);
        chk("jalr redirect_pc hold", bif.redirect_pc_o, 32'h120);

        // Mispredict, wrong-path branch during squash, stalls extending flush.
        drive(2'b01, 0, 32'h200, 32'h40, 0, 1, 32'h240);
        tick();
        drive(2'b01, 1, 32'h300, 32'h8, 0, 0, 0);
        chk("stall redirect_pc_o", bif.redirect_pc_o, 32'h204);
        chk("stall bht_upd_taken_o", bif.bht_upd_taken_o, 0);
        tick();
        bif.stall = 1;
        chk("wrongpath redirect_o", bif.redirect_o, 0);
        chk("wrongpath bht_upd_o", bif.bht_upd_o, 0);
        chk("stall flush N+2", bif.flush_o, 1);
        tick();
        chk("stall flush N+3", bif.flush_o, 1);
        tick();
        chk("stall flush N+4", bif.flush_o, 1);
        tick(); idle();
        chk("stall flush N+5", bif.flush_o, 1);
        tick();
        chk("stall flush N+6", bif.flush_o, 0);
        chk("stall redirect_pc hold", bif.redirect_pc_o, 32'h204);

        // Not-taken fall-through wraps past 2^32.
        drive(2'b01, 0, 32'hFFFF_FFFC, 32'h8, 0, 1, 32'h4);
        tick(); idle();
        chk("wrap redirect_o", bif.redirect_o, 1);
        chk("wrap redirect_pc_o", bif.redirect_pc_o, 32'h0);
        tick(); tick();
        chk("wrap flush done", bif.flush_o, 0);

        // Async reset during a squash.
        drive(2'b01, 1, 32'h400, 32'h10, 0, 0, 0);
        tick(); idle();
        chk("rst pre redirect_o", bif.redirect_o, 1);
        chk("rst pre flush_o", bif.flush_o, 1);
        #2 rst_n = 0;
        #1;
        chk("rst async redirect_o", bif.redirect_o, 0);
        chk("rst async flush_o", bif.flush_o, 0);
        chk("rst async redirect_pc_o", bif.redirect_pc_o, 0);
        tick();
        rst_n = 1;
        drive(2'b01, 1, 32'h500, 32'h10, 0, 1, 32'h510);
        tick(); idle();
        chk("post-rst flush_o", bif.flush_o, 0);
        chk("post-rst redirect_o", bif.redirect_o, 0);
        chk("post-rst bht_upd_o", bif.bht_upd_o, 1);
        chk("post-rst bht_upd_pc_o", bif.bht_upd_pc_o, 32'h500);
        tick();
        chk("post-rst flush N+2", bif.flush_o, 0);

`ifdef BR_STATS_EN
        force dut.stat_mispred_q = 32'hFFFF_FFFF;
        m_mp = 32'hFFFF_FFFF;
        tick();
        release dut.stat_mispred_q;
        drive(2'b10, 0, 32'h600, 32'h40, 0, 0, 0);
        tick(); idle();
        chk("stat saturate", stat_mispred, 32'hFFFF_FFFF);
        tick(); tick();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bif.ex_valid = ($urandom_range(0, 3) != 0);
            bif.ex_kind  = 2'($urandom_range(0, 3));
            bif.cmp_f    = 1'($urandom_range(0, 1));
            bif.ex_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                       : $urandom;
            bif.ex_imm   = $urandom;
            bif.ex_rs1   = $urandom;
            bif.stall    = ($urandom_range(0, 4) == 0);
            ref_resolve(bif.ex_kind, bif.cmp_f, bif.ex_pc, bif.ex_imm, bif.ex_rs1, tgt, tk, nxt);
            bif.pred_taken  = ($urandom_range(0, 9) < 7) ? tk : ~tk;
            bif.pred_target = ($urandom_range(0, 2) != 0) ? tgt
                                                          : tgt ^ (32'd1 << $urandom_range(0, 31));
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1;
        idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
